// File: rtl/q_row_fetch_if.sv
// Flip-request handshake, Q-memory config port and row output of q_row_fetch.
// The bench drives through master; the design sits on slave.
interface q_row_fetch_if #(
  parameter int RAM_SIZE = 10,
  parameter int ADDR_W   = 4
);
  logic                flip_valid;
  logic [ADDR_W-1:0]   flip_idx;
  logic                flip_ready;
  logic                cfg_we;
  logic [ADDR_W-1:0]   cfg_addr;
  logic [RAM_SIZE-1:0] cfg_data;
  logic [RAM_SIZE-1:0] Q_row;
  logic                update_enable;
  logic                busy;
  logic [ADDR_W:0]     fifo_level;
  logic                err_idx;

  modport master (
    output flip_valid, flip_idx, cfg_we, cfg_addr, cfg_data,
    input  flip_ready, Q_row, update_enable, busy, fifo_level, err_idx
  );

  modport slave (
    input  flip_valid, flip_idx, cfg_we, cfg_addr, cfg_data,
    output flip_ready, Q_row, update_enable, busy, fifo_level, err_idx
  );
endinterface

// File: rtl/q_row_fetch.sv
// Buffers spin-flip indices in a small FIFO and emits the matching Q-matrix row
// with a one-cycle update_enable pulse, at most one row every two cycles.
module q_row_fetch #(
  parameter int RAM_SIZE   = 10,
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  q_row_fetch_if.slave bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [ADDR_W:0]  LVL_FULL = (ADDR_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]  LVL_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]  LVL_ZERO = (ADDR_W+1)'(0);
  localparam logic [ADDR_W:0]  IDX_LIM  = (ADDR_W+1)'(RAM_SIZE);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, EMIT = 2'd2} state_t;

  state_t              state;
  state_t              next_state;
  logic [ADDR_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [ADDR_W:0]     count;
  logic [RAM_SIZE-1:0] qmem [RAM_SIZE];
  logic [RAM_SIZE-1:0] row_q;
  logic                emit_pulse;
  logic                err_seen;
  logic                full;
  logic                accept;
  logic                idx_ok;
  logic                cfg_ok;
  logic                push;
  logic                pop;
  logic                pending;
  logic [ADDR_W-1:0]   head;

  assign full    = (count == LVL_FULL);
  assign accept  = bus.flip_valid & ~full;
  assign idx_ok  = ({1'b0, bus.flip_idx} < IDX_LIM);
  assign cfg_ok  = ({1'b0, bus.cfg_addr} < IDX_LIM);
  assign push    = accept & idx_ok;
  assign pop     = (state == FETCH);
  // A push landing this cycle counts as work so an idle FSM reaches FETCH next cycle.
  assign pending = (count != LVL_ZERO) | push;
  assign head    = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= bus.flip_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= PTR_ZERO;
      rd_ptr <= PTR_ZERO;
      count  <= LVL_ZERO;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + LVL_ONE;
        2'b01:   count <= count - LVL_ONE;
        default: count <= count;
      endcase
    end
  end

  // Row read in FETCH sees pre-write contents when the same row is written that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RAM_SIZE; i++) begin
        qmem[i] <= {RAM_SIZE{1'b0}};
      end
    end else if (bus.cfg_we && cfg_ok) begin
      qmem[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (pending) next_state = FETCH;
        else         next_state = IDLE;
      end
      FETCH: next_state = EMIT;
      EMIT: begin
        if (pending) next_state = FETCH;
        else         next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q      <= {RAM_SIZE{1'b0}};
      emit_pulse <= 1'b0;
      err_seen   <= 1'b0;
    end else begin
      if (pop) begin
        row_q <= qmem[head];
      end
      emit_pulse <= (next_state == EMIT);
      if (accept && !idx_ok) begin
        err_seen <= 1'b1;
      end
    end
  end

  assign bus.flip_ready    = ~full;
  assign bus.Q_row         = row_q;
  assign bus.update_enable = emit_pulse;
  assign bus.busy          = (state != IDLE) | (count != LVL_ZERO);
  assign bus.fifo_level    = count;
  assign bus.err_idx       = err_seen;
endmodule

// File: tb/tb_q_row_fetch.sv
// Self-checking bench for q_row_fetch: directed scenarios plus a randomized run
// against a schedule-level model (fetch time = max(accept+1, previous fetch+2)).
module tb_q_row_fetch;
  localparam int RS = 10;
  localparam int AW = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  q_row_fetch_if #(.RAM_SIZE(RS), .ADDR_W(AW)) bus ();
  q_row_fetch #(.RAM_SIZE(RS), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {int idx; int fetch; logic [RS-1:0] row; int acc;} ent_t;

  ent_t          ents[$];
  logic [RS-1:0] mq [RS];
  logic [RS-1:0] m_row;
  bit            m_err;
  int            cyc;
  int            last_fetch;
  int            checks;
  int            errors;

  function automatic void model_reset();
    ents.delete();
    for (int i = 0; i < RS; i++) mq[i] = '0;
    m_row = '0;
    m_err = 1'b0;
    last_fetch = -10;
  endfunction

  // Occupancy during the current cycle: accepted earlier, not yet popped.
  function automatic int m_level();
    int n = 0;
    foreach (ents[i]) if (ents[i].acc < cyc && ents[i].fetch >= cyc) n++;
    return n;
  endfunction

  function automatic bit m_pulse();
    foreach (ents[i]) if (ents[i].fetch == cyc - 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_busy();
    bit b = (m_level() != 0);
    foreach (ents[i]) if (ents[i].fetch == cyc || ents[i].fetch == cyc - 1) b = 1'b1;
    return b;
  endfunction

  // Drives one cycle of inputs (called at negedge), advances the model, returns at next negedge.
  task automatic drive_cycle(input bit v, input int idx, input bit we, input int addr,
                             input logic [RS-1:0] data, input bit r);
    bit acc;
    int f;
    ent_t e;
    acc = v && (m_level() < DEPTH);
    bus.flip_valid = v;
    bus.flip_idx   = 4'(idx);
    bus.cfg_we     = we;
    bus.cfg_addr   = 4'(addr);
    bus.cfg_data   = data;
    rst            = r;
    if (r) begin
      model_reset();
    end else begin
      foreach (ents[i]) if (ents[i].fetch == cyc) ents[i].row = mq[ents[i].idx];
      if (acc) begin
        if (idx < RS) begin
          f = (cyc + 1 > last_fetch + 2) ? cyc + 1 : last_fetch + 2;
          e = '{idx: idx, fetch: f, row: '0, acc: cyc};
          ents.push_back(e);
          last_fetch = f;
        end else begin
          m_err = 1'b1;
        end
      end
      if (we && addr < RS) mq[addr] = data;
    end
    @(posedge clk);
    if (!r) foreach (ents[i]) if (ents[i].fetch == cyc) m_row = ents[i].row;
    cyc++;
    @(negedge clk);
    while (ents.size() > 0 && ents[0].fetch < cyc - 1) void'(ents.pop_front());
  endtask

  task automatic idle();
    drive_cycle(1'b0, 0, 1'b0, 0, '0, 1'b0);
  endtask

  task automatic test_reset();
    drive_cycle(1'b0, 0, 1'b0, 0, '0, 1'b1);
    checks++; if (bus.Q_row !== 10'd0) begin errors++; $display("FAIL reset_q_row got %h exp %h", bus.Q_row, 10'd0); end
    checks++; if (bus.update_enable !== 1'b0) begin errors++; $display("FAIL reset_ue got %b exp 0", bus.update_enable); end
    checks++; if (bus.flip_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.flip_ready); end
    checks++; if (bus.fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", bus.fifo_level); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.err_idx !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.err_idx); end
  endtask

  task automatic test_single();
    drive_cycle(1'b0, 0, 1'b1, 3, 10'h2A5, 1'b0);
    idle();
    drive_cycle(1'b1, 3, 1'b0, 0, '0, 1'b0);
    checks++; if (bus.update_enable !== 1'b0) begin errors++; $display("FAIL single_ue_t1 got %b exp 0", bus.update_enable); end
    idle();
    checks++; if (bus.update_enable !== 1'b1) begin errors++; $display("FAIL single_ue_t2 got %b exp 1", bus.update_enable); end
    checks++; if (bus.Q_row !== 10'h2A5) begin errors++; $display("FAIL single_row got %h exp %h", bus.Q_row, 10'h2A5); end
    idle();
    checks++; if (bus.update_enable !== 1'b0) begin errors++; $display("FAIL single_ue_t3 got %b exp 0", bus.update_enable); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_t3 got %b exp 0", bus.busy); end
    checks++; if (bus.Q_row !== 10'h2A5) begin errors++; $display("FAIL single_hold got %h exp %h", bus.Q_row, 10'h2A5); end
  endtask

  // Pushing every cycle outruns the 1-per-2-cycle drain, so the FIFO must fill.
  task automatic test_back_to_back();
    logic [RS-1:0] rows [8];
    int nxt = 0, np = 0, prev = 0;
    bit seen_full = 1'b0;
    bit acc;
    for (int i = 0; i < 8; i++) begin
      rows[i] = 10'($urandom);
      drive_cycle(1'b0, 0, 1'b1, i, rows[i], 1'b0);
    end
    idle();
    for (int k = 0; k < 40; k++) begin
      checks++; if (bus.update_enable !== m_pulse()) begin errors++; $display("FAIL burst_ue cyc %0d got %b exp %b", cyc, bus.update_enable, m_pulse()); end
      checks++; if (bus.flip_ready !== (m_level() < DEPTH)) begin errors++; $display("FAIL burst_ready cyc %0d got %b exp %b", cyc, bus.flip_ready, m_level() < DEPTH); end
      if (bus.flip_ready === 1'b0) seen_full = 1'b1;
      if (bus.update_enable === 1'b1) begin
        if (np < 8) begin
          checks++; if (bus.Q_row !== rows[np]) begin errors++; $display("FAIL burst_row %0d got %h exp %h", np, bus.Q_row, rows[np]); end
        end
        if (np > 0) begin
          checks++; if (cyc - prev !== 2) begin errors++; $display("FAIL burst_spacing %0d got %0d exp 2", np, cyc - prev); end
        end
        prev = cyc;
        np++;
      end
      acc = (nxt < 8) && (m_level() < DEPTH);
      drive_cycle(nxt < 8, nxt, 1'b0, 0, '0, 1'b0);
      if (acc) nxt++;
    end
    checks++; if (np !== 8) begin errors++; $display("FAIL burst_pulses got %0d exp 8", np); end
    checks++; if (seen_full !== 1'b1) begin errors++; $display("FAIL burst_full got %b exp 1", seen_full); end
  endtask

  task automatic test_bad_index();
    drive_cycle(1'b1, 12, 1'b0, 0, '0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus.update_enable !== 1'b0) begin errors++; $display("FAIL bad_ue k%0d got %b exp 0", k, bus.update_enable); end
      checks++; if (bus.fifo_level !== 5'd0) begin errors++; $display("FAIL bad_level k%0d got %0d exp 0", k, bus.fifo_level); end
      checks++; if (bus.err_idx !== 1'b1) begin errors++; $display("FAIL bad_err k%0d got %b exp 1", k, bus.err_idx); end
      idle();
    end
    drive_cycle(1'b0, 0, 1'b0, 0, '0, 1'b1);
    checks++; if (bus.err_idx !== 1'b0) begin errors++; $display("FAIL bad_err_clr got %b exp 0", bus.err_idx); end
  endtask

  task automatic test_collision();
    logic [RS-1:0] a, b;
    a = 10'($urandom) | 10'h001;
    b = ~a;
    drive_cycle(1'b0, 0, 1'b1, 2, a, 1'b0);
    idle();
    drive_cycle(1'b1, 2, 1'b0, 0, '0, 1'b0);
    drive_cycle(1'b0, 0, 1'b1, 2, b, 1'b0);
    checks++; if (bus.update_enable !== 1'b1) begin errors++; $display("FAIL coll_ue1 got %b exp 1", bus.update_enable); end
    checks++; if (bus.Q_row !== a) begin errors++; $display("FAIL coll_old got %h exp %h", bus.Q_row, a); end
    idle();
    drive_cycle(1'b1, 2, 1'b0, 0, '0, 1'b0);
    idle();
    checks++; if (bus.update_enable !== 1'b1) begin errors++; $display("FAIL coll_ue2 got %b exp 1", bus.update_enable); end
    checks++; if (bus.Q_row !== b) begin errors++; $display("FAIL coll_new got %h exp %h", bus.Q_row, b); end
  endtask

  task automatic test_reset_midop();
    for (int i = 5; i < 8; i++) drive_cycle(1'b0, 0, 1'b1, i, 10'h3FF - 10'(i), 1'b0);
    idle();
    for (int i = 5; i < 8; i++) drive_cycle(1'b1, i, 1'b0, 0, '0, 1'b0);
    drive_cycle(1'b0, 0, 1'b0, 0, '0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus.update_enable !== 1'b0) begin errors++; $display("FAIL mid_ue k%0d got %b exp 0", k, bus.update_enable); end
      checks++; if (bus.fifo_level !== 5'd0) begin errors++; $display("FAIL mid_level k%0d got %0d exp 0", k, bus.fifo_level); end
      checks++; if (bus.Q_row !== 10'd0) begin errors++; $display("FAIL mid_row k%0d got %h exp 0", k, bus.Q_row); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy k%0d got %b exp 0", k, bus.busy); end
      idle();
    end
    drive_cycle(1'b1, 5, 1'b0, 0, '0, 1'b0);
    idle();
    checks++; if (bus.update_enable !== 1'b1) begin errors++; $display("FAIL mid_ue_after got %b exp 1", bus.update_enable); end
    checks++; if (bus.Q_row !== 10'd0) begin errors++; $display("FAIL mid_qmem_clr got %h exp 0", bus.Q_row); end
  endtask

  task automatic test_random();
    bit v, we, r;
    int idx, addr;
    for (int k = 0; k < 600; k++) begin
      checks++; if (bus.update_enable !== m_pulse()) begin errors++; $display("FAIL rnd_ue cyc %0d got %b exp %b", cyc, bus.update_enable, m_pulse()); end
      checks++; if (bus.Q_row !== m_row) begin errors++; $display("FAIL rnd_row cyc %0d got %h exp %h", cyc, bus.Q_row, m_row); end
      checks++; if (bus.fifo_level !== 5'(m_level())) begin errors++; $display("FAIL rnd_level cyc %0d got %0d exp %0d", cyc, bus.fifo_level, m_level()); end
      checks++; if (bus.flip_ready !== (m_level() < DEPTH)) begin errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", cyc, bus.flip_ready, m_level() < DEPTH); end
      checks++; if (bus.busy !== m_busy()) begin errors++; $display("FAIL rnd_busy cyc %0d got %b exp %b", cyc, bus.busy, m_busy()); end
      checks++; if (bus.err_idx !== m_err) begin errors++; $display("FAIL rnd_err cyc %0d got %b exp %b", cyc, bus.err_idx, m_err); end
      v    = ($urandom_range(0, 99) < 60);
      idx  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
      we   = ($urandom_range(0, 99) < 30);
      addr = int'($urandom_range(0, 15));
      r    = ($urandom_range(0, 149) == 0);
      drive_cycle(v, idx, we, addr, 10'($urandom), r);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    bus.flip_valid = 1'b0;
    bus.flip_idx   = 4'd0;
    bus.cfg_we     = 1'b0;
    bus.cfg_addr   = 4'd0;
    bus.cfg_data   = 10'd0;
    rst            = 1'b1;
    model_reset();
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_bad_index();
    test_collision();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
